// File: rtl/btn_bounce_gen.sv
// btn_bounce_gen: bouncing push-button waveform generator with request/ready/done handshake.
// Optional BTN_GEN_ACTIVE_LOW_EN inverts btn_out for active-low board buttons.
module btn_bounce_gen #(
    parameter int          BOUNCE_CYCLES = 20,
    parameter int          GLITCH_W      = 3,
    parameter int          HOLD_W        = 24,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              ready,
    output logic              done,
    output logic              btn_out
);
    localparam int WW = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [WW-1:0] WIN_INIT = WW'(BOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE} state_t;

    state_t              state, state_nxt;
    logic [15:0]         lfsr;
    logic [WW-1:0]       win_cnt;
    logic [GLITCH_W-1:0] seg_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                btn;
    logic                win_end;

    assign win_end = (win_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         state_nxt = start ? BOUNCE_PRESS : IDLE;
            BOUNCE_PRESS: state_nxt = win_end ? HOLD : BOUNCE_PRESS;
            HOLD:         state_nxt = (hold_cnt == '0) ? BOUNCE_RELEASE : HOLD;
            default:      state_nxt = win_end ? IDLE : BOUNCE_RELEASE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
`ifdef BTN_GEN_ACTIVE_LOW_EN
        btn_out = ~btn;
`else
        btn_out = btn;
`endif
    end

    // hold_cnt doubles as the latched hold length until the press window ends
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            btn      <= 1'b0;
            done     <= 1'b0;
            win_cnt  <= '0;
            seg_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    btn      <= 1'b1;
                    win_cnt  <= WIN_INIT;
                    seg_cnt  <= lfsr[GLITCH_W-1:0];
                    hold_cnt <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
                end
                HOLD: if (hold_cnt == '0) begin
                    btn     <= 1'b0;
                    win_cnt <= WIN_INIT;
                    seg_cnt <= lfsr[GLITCH_W-1:0];
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
                default: if (win_end) begin
                    btn  <= (state == BOUNCE_PRESS);
                    done <= (state == BOUNCE_RELEASE);
                    if (state == BOUNCE_PRESS) hold_cnt <= hold_cnt - 1'b1;
                end else begin
                    win_cnt <= win_cnt - 1'b1;
                    btn     <= (seg_cnt == '0) ? ~btn : btn;
                    seg_cnt <= (seg_cnt == '0) ? lfsr[GLITCH_W-1:0] : seg_cnt - 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btn_bounce_gen.sv
// tb_btn_bounce_gen: scoreboard bench checking press timing and waveform shape against a cycle-window model.
module tb_btn_bounce_gen;
    localparam int BC = 20;
    localparam int G  = 3;
`ifdef BTN_GEN_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [23:0] hold_cycles = '0;
    logic        ready, done, btn_out, btn;
    int          checks = 0, errors = 0, cyc = 0;
    int          exp_q[$];
    int          e0 = -1, cur_h = 1, last_chg = 0, toggles = 0;
    logic        prev_btn = 1'b0;

    btn_bounce_gen dut (
        .clk(clk), .reset(reset), .start(start), .hold_cycles(hold_cycles),
        .ready(ready), .done(done), .btn_out(btn_out)
    );

    assign btn = btn_out ^ INV;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Monitor: window model of one press relative to the accept edge e0
    always @(negedge clk) begin
        if (!reset) begin
            int t;
            t = cyc - e0;
            if (btn !== prev_btn) begin
                last_chg = cyc;
                if (e0 >= 0 && t >= 1 && t <= BC - 1) toggles++;
            end
            prev_btn = btn;
            if (done) begin
                if (exp_q.size() == 0) check("spurious_done", 1, 0);
                else begin
                    check("done_cycle", cyc, exp_q.pop_front());
                    check("ready_with_done", int'(ready), 1);
                end
            end
            if (e0 < 0) begin
                check("idle_btn", int'(btn), 0);
            end else if (t >= 0) begin
                if (t == 0) begin
                    toggles = 0;
                    check("btn_after_accept", int'(btn), 1);
                    check("busy_after_accept", int'(ready), 0);
                end
                if ((t >= 1 && t <= BC - 1) || (t > BC + cur_h && t <= 2*BC + cur_h - 1))
                    check("seg_len_bound", int'(cyc - last_chg < 2**G), 1);
                if (t == BC) check("press_toggled", int'(toggles > 0), 1);
                if (t >= BC && t < BC + cur_h) check("hold_high", int'(btn), 1);
                if (t == BC + cur_h) check("release_first_low", int'(btn), 0);
                if (t == 2*BC + cur_h) begin
                    check("done_at_end", int'(done), 1);
                    check("btn_low_at_end", int'(btn), 0);
                    e0 = -1;
                end
            end
        end
    end

    task automatic run_req(input int hv, input bit repulse, input int abort_at);
        int n = 0;
        while (!ready && n < 200) begin @(negedge clk); n++; end
        if (!ready) check("ready_timeout", 0, 1);
        hold_cycles = 24'(hv);
        cur_h = (hv == 0) ? 1 : hv;
        e0 = cyc + 1;
        exp_q.push_back(e0 + 2*BC + cur_h);
        start = 1'b1;
        @(negedge clk);
        hold_cycles = 24'($urandom);
        for (int k = 0; k < 2*BC + cur_h; k++) begin
            start = repulse && ($urandom_range(0, 3) == 0);
            if (k == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                check("abort_btn", int'(btn), 0);
                check("abort_ready", int'(ready), 1);
                check("abort_done", int'(done), 0);
                exp_q.delete();
                e0 = -1;
                reset = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_btn", int'(btn), 0);
        check("reset_ready", int'(ready), 1);
        check("reset_done", int'(done), 0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_ready", int'(ready), 1);
        run_req(50, 1'b0, -1);
        run_req(0, 1'b0, -1);
        run_req(50, 1'b1, -1);
        run_req(50, 1'b0, 30);
        run_req(5, 1'b0, -1);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_req($urandom_range(0, 40), 1'($urandom_range(0, 1)), -1);
        end
        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
